// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, TERC4 codewords,
// period classes and the word-alignment lock states.
package tmds_pkg;

  localparam logic [9:0] CTL_00 = 10'b1101010100;
  localparam logic [9:0] CTL_01 = 10'b0010101011;
  localparam logic [9:0] CTL_10 = 10'b0101010100;
  localparam logic [9:0] CTL_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    PC_CTRL    = 2'b00,
    PC_VIDEO   = 2'b01,
    PC_DATA    = 2'b10,
    PC_INVALID = 2'b11
  } period_t;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  typedef struct packed {
    logic       v;
    logic [9:0] q;
    logic       di;
    logic       is_ctl;
    logic [1:0] ctl;
    logic       is_terc;
    logic [3:0] terc;
  } s1_t;

  function automatic logic [9:0] terc4_code(input logic [3:0] d);
    logic [9:0] c;
    c = '0;
    unique case (d)
      4'h0: c = 10'b1010011100;
      4'h1: c = 10'b1001100011;
      4'h2: c = 10'b1011100100;
      4'h3: c = 10'b1011100010;
      4'h4: c = 10'b0101110001;
      4'h5: c = 10'b0100011110;
      4'h6: c = 10'b0110001110;
      4'h7: c = 10'b0100111100;
      4'h8: c = 10'b1011001100;
      4'h9: c = 10'b0100111001;
      4'hA: c = 10'b0110011100;
      4'hB: c = 10'b1011000110;
      4'hC: c = 10'b1010001110;
      4'hD: c = 10'b1001110001;
      4'hE: c = 10'b0101100011;
      4'hF: c = 10'b1011000011;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] ones10(input logic [9:0] q);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 10; i++) n = n + {3'b000, q[i]};
    return n;
  endfunction

endpackage

// File: rtl/tmds_lock_fsm.sv
// Word-alignment tracker: counts control-token runs, requests
// bit-slips while searching and drops lock after a long token gap.
module tmds_lock_fsm
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN     = 8,
  parameter int SLIP_TIMEOUT = 2048,
  parameter int LOCK_TIMEOUT = 65536
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       sym_v_i,
  input  logic       is_ctl_i,
  input  logic [1:0] ctl_i,
  output logic       lock_nxt_o,
  output logic       locked_o,
  output logic       bitslip_o
);

  localparam int RW = $clog2(CTRL_RUN) + 1;
  localparam int SW = $clog2(SLIP_TIMEOUT) + 1;
  localparam int GW = $clog2(LOCK_TIMEOUT) + 1;

  localparam logic [RW-1:0] RUN_MAX   = RW'(CTRL_RUN);
  localparam logic [SW-1:0] SLIP_LAST = SW'(SLIP_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_MAX   = GW'(LOCK_TIMEOUT);

  lock_state_t   st_q, st_d;
  logic [RW-1:0] run_q, run_d, run_nx;
  logic [SW-1:0] slip_q, slip_d;
  logic [GW-1:0] gap_q, gap_d, gap_nx;
  logic [1:0]    fl_q, fl_d;
  logic [1:0]    prev_q, prev_d;
  logic          bs_q, bs_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      st_q   <= SEARCH;
      run_q  <= '0;
      slip_q <= '0;
      gap_q  <= '0;
      fl_q   <= '0;
      prev_q <= '0;
      bs_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      run_q  <= run_d;
      slip_q <= slip_d;
      gap_q  <= gap_d;
      fl_q   <= fl_d;
      prev_q <= prev_d;
      bs_q   <= bs_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    run_d  = run_q;
    slip_d = slip_q;
    gap_d  = gap_q;
    fl_d   = fl_q;
    prev_d = prev_q;
    bs_d   = 1'b0;
    run_nx = '0;
    if (is_ctl_i) begin
      if (run_q != '0 && ctl_i == prev_q)
        run_nx = (&run_q) ? run_q : run_q + RW'(1);
      else
        run_nx = RW'(1);
    end
    gap_nx = is_ctl_i ? '0 :
             ((&gap_q) ? gap_q : gap_q + GW'(1));
    if (sym_v_i) begin
      unique case (st_q)
        SEARCH: begin
          // fl_q skips symbols still in flight from before a slip
          if (fl_q != 2'd0) begin
            fl_d = fl_q - 2'd1;
          end else if (run_nx >= RUN_MAX) begin
            st_d   = LOCKED;
            run_d  = '0;
            slip_d = '0;
            gap_d  = '0;
          end else if (slip_q >= SLIP_LAST) begin
            bs_d   = 1'b1;
            run_d  = '0;
            slip_d = '0;
            fl_d   = 2'd2;
          end else begin
            run_d  = run_nx;
            prev_d = ctl_i;
            slip_d = (&slip_q) ? slip_q : slip_q + SW'(1);
          end
        end
        LOCKED: begin
          if (gap_nx >= GAP_MAX) begin
            st_d   = SEARCH;
            gap_d  = '0;
            run_d  = '0;
            slip_d = '0;
            fl_d   = '0;
          end else begin
            gap_d = gap_nx;
          end
        end
      endcase
    end
  end

  assign lock_nxt_o = (st_d == LOCKED);
  assign locked_o   = (st_q == LOCKED);
  assign bitslip_o  = bs_q;

endmodule

// File: rtl/tmds_decoder.sv
// Per-channel TMDS receive decoder, 2-cycle latency.
// Define DISP_CHECK_EN to build the running-disparity checker.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN     = 8,
  parameter int SLIP_TIMEOUT = 2048,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int DISP_LIMIT   = 10
) (
  input  logic       clklow,
  input  logic       reset,
  input  logic [9:0] q_in,
  input  logic       di_window,
  output logic [1:0] state,
  output logic [7:0] pix_data,
  output logic [1:0] H_VSync_Ctr,
  output logic [3:0] aux_data,
  output logic       locked,
  output logic       bitslip,
  output logic       disp_err
);

  s1_t s1_d, s1_q;

  always_comb begin
    s1_d        = '0;
    s1_d.v      = 1'b1;
    s1_d.q      = q_in;
    s1_d.di     = di_window;
    s1_d.is_ctl = 1'b1;
    unique case (1'b1)
      q_in == CTL_00: s1_d.ctl = 2'b00;
      q_in == CTL_01: s1_d.ctl = 2'b01;
      q_in == CTL_10: s1_d.ctl = 2'b10;
      q_in == CTL_11: s1_d.ctl = 2'b11;
      default:        s1_d.is_ctl = 1'b0;
    endcase
    for (int i = 0; i < 16; i++) begin
      if (q_in == terc4_code(4'(i))) begin
        s1_d.is_terc = 1'b1;
        s1_d.terc    = 4'(i);
      end
    end
  end

  always_ff @(posedge clklow) begin
    if (!reset) s1_q <= '0;
    else        s1_q <= s1_d;
  end

  logic lock_nxt;

  tmds_lock_fsm #(
    .CTRL_RUN    (CTRL_RUN),
    .SLIP_TIMEOUT(SLIP_TIMEOUT),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) u_lock (
    .clk_i     (clklow),
    .rst_ni    (reset),
    .sym_v_i   (s1_q.v),
    .is_ctl_i  (s1_q.is_ctl),
    .ctl_i     (s1_q.ctl),
    .lock_nxt_o(lock_nxt),
    .locked_o  (locked),
    .bitslip_o (bitslip)
  );

  period_t    cls, st_d, st_q;
  logic [7:0] qd, vid;
  logic [7:0] pix_d, pix_q;
  logic [1:0] hv_d, hv_q;
  logic [3:0] aux_d, aux_q;

  always_comb begin
    qd     = s1_q.q[9] ? ~s1_q.q[7:0] : s1_q.q[7:0];
    vid    = '0;
    vid[0] = qd[0];
    for (int i = 1; i < 8; i++)
      vid[i] = s1_q.q[8] ? (qd[i] ^ qd[i-1]) : ~(qd[i] ^ qd[i-1]);
    cls   = PC_VIDEO;
    pix_d = pix_q;
    hv_d  = hv_q;
    aux_d = aux_q;
    priority case (1'b1)
      s1_q.is_ctl: begin
        cls  = PC_CTRL;
        hv_d = s1_q.ctl;
      end
      s1_q.di && s1_q.is_terc: begin
        cls   = PC_DATA;
        aux_d = s1_q.terc;
      end
      s1_q.di: cls = PC_INVALID;
      default: pix_d = vid;
    endcase
    // class follows the lock decision taken for this same symbol
    st_d = lock_nxt ? cls : PC_INVALID;
  end

  always_ff @(posedge clklow) begin
    if (!reset) begin
      st_q  <= PC_CTRL;
      pix_q <= '0;
      hv_q  <= '0;
      aux_q <= '0;
    end else if (s1_q.v) begin
      st_q  <= st_d;
      pix_q <= pix_d;
      hv_q  <= hv_d;
      aux_q <= aux_d;
    end
  end

  assign state       = st_q;
  assign pix_data    = pix_q;
  assign H_VSync_Ctr = hv_q;
  assign aux_data    = aux_q;

`ifdef DISP_CHECK_EN
  localparam int AW = $clog2(DISP_LIMIT + 11) + 2;
  localparam logic signed [AW-1:0] LIM = AW'(DISP_LIMIT);

  logic signed [AW-1:0] acc_q, acc_d, acc_s;
  logic signed [5:0]    sym_disp;
  logic                 err_q, err_d;

  always_comb begin
    sym_disp = $signed({1'b0, ones10(s1_q.q), 1'b0}) - 6'sd10;
    acc_s    = acc_q + AW'(sym_disp);
    acc_d    = acc_q;
    err_d    = err_q;
    // once flagged the sum is frozen; only a control token clears it
    if (s1_q.is_ctl) begin
      acc_d = '0;
      err_d = 1'b0;
    end else if (s1_q.di) begin
      acc_d = '0;
    end else if (!err_q) begin
      acc_d = acc_s;
      err_d = (acc_s > LIM) || (acc_s < -LIM);
    end
  end

  always_ff @(posedge clklow) begin
    if (!reset) begin
      acc_q <= '0;
      err_q <= 1'b0;
    end else if (s1_q.v) begin
      acc_q <= acc_d;
      err_q <= err_d;
    end
  end

  assign disp_err = err_q;
`else
  assign disp_err = (DISP_LIMIT < 0);
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Bench for tmds_decoder: directed steps plus random symbols
// checked against a symbol-level reference model.
module tb_tmds_decoder;

  localparam int CTRL_RUN = 8;
  localparam int SLIP_T   = 2048;
  localparam int LOCK_T   = 4096;
  localparam int DISP_L   = 10;

  localparam logic [9:0] CTL [4] = '{
    10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
  };
  localparam logic [9:0] TERC [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };
  localparam logic [9:0] ROT = 10'b1010101001;

  typedef logic [18:0] vec_t;

  logic       clklow = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] q_in = '0;
  logic       di_window = 1'b0;
  logic [1:0] state;
  logic [7:0] pix_data;
  logic [1:0] H_VSync_Ctr;
  logic [3:0] aux_data;
  logic       locked, bitslip, disp_err;

  int vectors = 0;
  int miscompares = 0;

  tmds_decoder #(
    .CTRL_RUN    (CTRL_RUN),
    .SLIP_TIMEOUT(SLIP_T),
    .LOCK_TIMEOUT(LOCK_T),
    .DISP_LIMIT  (DISP_L)
  ) dut (
    .clklow     (clklow),
    .reset      (reset),
    .q_in       (q_in),
    .di_window  (di_window),
    .state      (state),
    .pix_data   (pix_data),
    .H_VSync_Ctr(H_VSync_Ctr),
    .aux_data   (aux_data),
    .locked     (locked),
    .bitslip    (bitslip),
    .disp_err   (disp_err)
  );

  always #5 clklow = ~clklow;

  // reference model state, in plain integers
  int         m_locked, m_run, m_prev, m_slip, m_flush, m_gap, m_acc;
  logic       m_err;
  logic [7:0] m_pix;
  logic [1:0] m_hv;
  logic [3:0] m_aux;
  vec_t       expq[$];
  string      phase = "reset";

  function automatic int ctl_idx(input logic [9:0] s);
    for (int i = 0; i < 4; i++) if (s == CTL[i]) return i;
    return -1;
  endfunction

  function automatic int terc_idx(input logic [9:0] s);
    for (int i = 0; i < 16; i++) if (s == TERC[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] video(input logic [9:0] s);
    logic [7:0] d, o;
    d    = s[9] ? ~s[7:0] : s[7:0];
    o    = '0;
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = d[i] ^ d[i-1] ^ ~s[8];
    return o;
  endfunction

  function automatic vec_t obs();
    return {locked, bitslip, state, pix_data, H_VSync_Ctr, aux_data, disp_err};
  endfunction

  task automatic model_reset();
    m_locked = 0; m_run = 0; m_prev = 0; m_slip = 0;
    m_flush = 0; m_gap = 0; m_acc = 0; m_err = 1'b0;
    m_pix = '0; m_hv = '0; m_aux = '0;
  endtask

  task automatic model_step(input logic [9:0] s, input logic di, output vec_t e);
    int c, t, bs, cls;
    c  = ctl_idx(s);
    t  = terc_idx(s);
    bs = 0;
    if (m_locked == 0) begin
      if (m_flush > 0) m_flush--;
      else begin
        if (c >= 0) begin
          m_run  = (m_run > 0 && c == m_prev) ? m_run + 1 : 1;
          m_prev = c;
        end else m_run = 0;
        if (m_run >= CTRL_RUN) begin
          m_locked = 1; m_run = 0; m_slip = 0; m_gap = 0;
        end else if (m_slip == SLIP_T - 1) begin
          bs = 1; m_run = 0; m_slip = 0; m_flush = 2;
        end else m_slip++;
      end
    end else begin
      m_gap = (c >= 0) ? 0 : m_gap + 1;
      if (m_gap >= LOCK_T) begin
        m_locked = 0; m_run = 0; m_slip = 0; m_flush = 0; m_gap = 0;
      end
    end
    if (c >= 0) begin
      cls = 0; m_hv = 2'(c);
    end else if (di && t >= 0) begin
      cls = 2; m_aux = 4'(t);
    end else if (di) cls = 3;
    else begin
      cls = 1; m_pix = video(s);
    end
`ifdef DISP_CHECK_EN
    if (c >= 0) begin
      m_acc = 0; m_err = 1'b0;
    end else if (di) m_acc = 0;
    else begin
      m_acc += 2 * $countones(s) - 10;
      if (m_acc > DISP_L || m_acc < -DISP_L) m_err = 1'b1;
    end
`endif
    if (m_locked == 0) cls = 3;
    e = {m_locked[0], bs[0], cls[1:0], m_pix, m_hv, m_aux, m_err};
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply(input logic [9:0] s, input logic di);
    vec_t e;
    q_in      = s;
    di_window = di;
    model_step(s, di, e);
    expq.push_back(e);
    @(posedge clklow);
    #1;
    if (expq.size() >= 2) check(phase, 32'(obs()), 32'(expq.pop_front()));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clklow);
    #1;
    check("reset outputs", 32'(obs()), 32'd0);
    reset = 1'b1;
    expq.delete();
    model_reset();
  endtask

  function automatic logic [9:0] rand_video();
    logic [9:0] s;
    s = 10'($urandom);
    while (ctl_idx(s) >= 0) s = 10'($urandom);
    return s;
  endfunction

  initial begin
    int n_pulse, last, first, k;
    model_reset();
    do_reset();

    phase = "lock ctl00";
    for (int i = 0; i < 8; i++) apply(CTL[0], 1'b0);
    check("pre-lock locked", 32'(locked), 32'd0);
    apply(CTL[0], 1'b0);
    check("lock locked", 32'(locked), 32'd1);
    check("lock state", 32'(state), 32'd0);
    check("lock hv", 32'(H_VSync_Ctr), 32'd0);

    phase = "video";
    apply(10'b0100000000, 1'b0);
    apply(10'b1000000000, 1'b0);
    check("video pix 00", 32'(pix_data), 32'h00);
    check("video state", 32'(state), 32'd1);
    apply(CTL[0], 1'b0);
    check("video pix ff", 32'(pix_data), 32'hff);

    phase = "terc4";
    apply(TERC[0], 1'b1);
    apply(TERC[15], 1'b1);
    check("terc aux 0", 32'(aux_data), 32'h0);
    check("terc state", 32'(state), 32'd2);
    apply(10'b0000000000, 1'b1);
    check("terc aux f", 32'(aux_data), 32'hf);
    apply(CTL[0], 1'b0);
    check("terc bad state", 32'(state), 32'd3);
    check("terc bad aux hold", 32'(aux_data), 32'hf);
    apply(CTL[0], 1'b0);
    check("ctl after terc", 32'(state), 32'd0);

`ifdef DISP_CHECK_EN
    phase = "disparity";
    apply(10'b1111111110, 1'b0);
    apply(10'b1111111110, 1'b0);
    check("disp after 1st", 32'(disp_err), 32'd0);
    apply(CTL[0], 1'b0);
    check("disp after 2nd", 32'(disp_err), 32'd1);
    apply(CTL[0], 1'b0);
    check("disp cleared", 32'(disp_err), 32'd0);
`endif

    phase = "random";
    for (int i = 0; i < 1500; i++) begin
      k = int'($urandom_range(0, 3));
      if (k == 0)      apply(CTL[$urandom_range(0, 3)], 1'($urandom));
      else if (k == 1) apply(TERC[$urandom_range(0, 15)], 1'b1);
      else if (k == 2) apply(10'($urandom), 1'($urandom));
      else             apply(rand_video(), 1'b0);
    end
    apply(CTL[0], 1'b0);

    phase = "lock timeout";
    for (int i = 0; i < LOCK_T; i++) apply(rand_video(), 1'b0);
    apply(CTL[1], 1'b0);
    check("timeout locked", 32'(locked), 32'd0);
    check("timeout state", 32'(state), 32'd3);
    for (int i = 0; i < 7; i++) apply(CTL[1], 1'b0);
    apply(CTL[1], 1'b0);
    check("relock locked", 32'(locked), 32'd1);
    check("relock hv", 32'(H_VSync_Ctr), 32'd1);
    check("relock state", 32'(state), 32'd0);

    phase = "mid-lock reset";
    do_reset();

    phase = "bitslip search";
    n_pulse = 0;
    last    = 0;
    first   = 0;
    for (int i = 1; i <= 3 * (SLIP_T + 2) + 20; i++) begin
      apply(ROT, 1'b0);
      if (bitslip === 1'b1) begin
        if (n_pulse == 0) first = i;
        else check("slip interval", 32'(i - last), 32'(SLIP_T + 2));
        last = i;
        n_pulse++;
      end
    end
    check("slip first", 32'(first), 32'(SLIP_T + 1));
    check("slip count", 32'(n_pulse), 32'd3);
    check("search locked", 32'(locked), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
